// File: rtl/bus_pkg.sv
// Shared definitions for the memory responder: FSM encoding, transfer direction
// constants, the default I/O register address and the latched request layout.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [31:0] IO_ADDR_DEFAULT = 32'hFFFF_FFF0;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // True when a word address falls inside a RAM of 2**bits words.
    function automatic logic addr_in_range(input logic [31:0] addr, input int bits);
        if (bits >= 32) return 1'b1;
        return (addr >> bits) == 32'd0;
    endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, no reset on contents.
module word_ram #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: word RAM plus one memory-mapped output register,
// with registered ready/err/rdata and an IDLE -> WAIT -> RESP handshake.
module mem_responder
    import bus_pkg::*;
#(
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] io_out
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    bus_req_t    lat_q, lat_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] io_q, io_d;

    bus_req_t    src;
    logic        src_ram, src_io, lat_ram, lat_io;
    logic        enter_resp;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // The response is resolved on the edge entering RESP; with no wait states
    // that edge is the accepting one, so the live request is used directly.
    always_comb begin
        src     = (state_q == ST_IDLE) ? '{rw: rw, addr: address, wdata: wdata} : lat_q;
        src_ram = addr_in_range(src.addr, ADDR_BITS);
        src_io  = (src.addr == IO_ADDR);
        lat_ram = addr_in_range(lat_q.addr, ADDR_BITS);
        lat_io  = (lat_q.addr == IO_ADDR);
        ram_we  = (state_q == ST_RESP) && (lat_q.rw == RW_WRITE) && lat_ram;
    end

    word_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk_i  (clock),
        .we_i   (ram_we),
        .addr_i (src.addr[ADDR_BITS-1:0]),
        .wdata_i(lat_q.wdata),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        io_d       = io_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    lat_d = src;
                    if (WAIT_STATES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) enter_resp = 1'b1;
                else               cnt_d      = cnt_q - 4'd1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (lat_q.rw == RW_WRITE && !lat_ram && lat_io) io_d = lat_q.wdata;
            end
            default: state_d = ST_IDLE;
        endcase

        // Writes leave rdata alone; only read responses refresh it.
        if (enter_resp) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = !(src_ram || src_io);
            if (src.rw == RW_READ) begin
                if (src_ram)     rdata_d = ram_rdata;
                else if (src_io) rdata_d = io_q;
                else             rdata_d = 32'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            lat_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            io_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            io_q    <= io_d;
        end
    end

    assign rdata  = rdata_q;
    assign ready  = ready_q;
    assign err    = err_q;
    assign io_out = io_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: one instance with one wait state, one with
// none, both scored against a word-array model of the responder's memory map.
module tb_mem_responder;

    localparam logic [31:0] IO = 32'hFFFF_FFF0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req     [2];
    logic        rw      [2];
    logic [31:0] address [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic        err     [2];
    logic [31:0] io_out  [2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_m [2][256];
    logic [31:0] io_m  [2];
    logic [31:0] rd_m  [2];

    always #5 clock = ~clock;

    mem_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) u_dut1 (
        .clock(clock), .reset(reset), .req(req[0]), .rw(rw[0]), .address(address[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .io_out(io_out[0])
    );

    mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset(reset), .req(req[1]), .rw(rw[1]), .address(address[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .io_out(io_out[1])
    );

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One complete transfer on instance d, scored against the model.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = !(a < 32'd256 || a == IO);
        exp_rd  = rd_m[d];
        if (!w) exp_rd = (a < 32'd256) ? mem_m[d][a[7:0]] : (a == IO) ? io_m[d] : 32'd0;

        @(negedge clock);
        req[d] = 1'b1; rw[d] = w; address[d] = a; wdata[d] = wd;
        @(posedge clock); #1;
        // Junk on the bus while busy must not disturb the latched request.
        req[d] = 1'b1; rw[d] = ~w; address[d] = $urandom; wdata[d] = $urandom;
        lat = 0;
        while (ready[d] !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        req[d] = 1'b0;
        chk("latency", 32'(lat), 32'(ws(d)));
        chk("err", 32'(err[d]), 32'(exp_err));
        chk("rdata", rdata[d], exp_rd);

        rd_m[d] = exp_rd;
        if (w) begin
            if (a < 32'd256) mem_m[d][a[7:0]] = wd;
            else if (a == IO) io_m[d] = wd;
        end
        @(posedge clock); #1;
        chk("ready_one_cycle", 32'(ready[d]), 32'd0);
        chk("err_clear", 32'(err[d]), 32'd0);
        chk("io_out", io_out[d], io_m[d]);
        chk("rdata_hold", rdata[d], rd_m[d]);
    endtask

    initial begin
        int          seen[$];
        int          gap;
        logic [31:0] a;

        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; rw[d] = 1'b0; address[d] = 32'd0; wdata[d] = 32'd0;
            rd_m[d] = 32'd0; io_m[d] = 32'd0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ready[d]), 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_io", io_out[d], 32'd0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) txn(d, 1'b1, 32'(i), $urandom);

        // Write then read back a RAM word.
        txn(0, 1'b1, 32'd5, 32'h1234_5678);
        txn(0, 1'b0, 32'd5, 32'd0);
        chk("rd5_value", rdata[0], 32'h1234_5678);

        // req held high, alternating reads of words 0 and 1.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (ready[0] === 1'b1) begin
                chk("thr_rdata", rdata[0], (seen.size() == 0) ? mem_m[0][0] : mem_m[0][1]);
                seen.push_back(i);
            end
            req[0] = 1'b1; rw[0] = 1'b0; address[0] = 32'(i % 2);
        end
        @(negedge clock) req[0] = 1'b0;
        rd_m[0] = mem_m[0][0];
        repeat (2) @(posedge clock);
        #1;
        gap = (seen.size() >= 2) ? seen[1] - seen[0] : -1;
        chk("thr_pulses", 32'(seen.size()), 32'd2);
        chk("thr_gap", 32'(gap), 32'd3);
        chk("thr_rdata_last", rdata[0], rd_m[0]);

        // Reset during the wait state of a write to word 7.
        @(negedge clock);
        req[0] = 1'b1; rw[0] = 1'b1; address[0] = 32'd7; wdata[0] = ~mem_m[0][7];
        @(posedge clock); #1;
        req[0] = 1'b0;
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("abort_ready", 32'(ready[d]), 32'd0);
            chk("abort_rdata", rdata[d], 32'd0);
            chk("abort_io", io_out[d], 32'd0);
            rd_m[d] = 32'd0; io_m[d] = 32'd0;
        end
        @(posedge clock); #1;
        chk("abort_no_ready", 32'(ready[0]), 32'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_ready", 32'(ready[0]), 32'd0);
        txn(0, 1'b0, 32'd7, 32'd0);

        // I/O register write and read-back.
        txn(0, 1'b1, IO, 32'h0000_00A5);
        chk("io_a5", io_out[0], 32'h0000_00A5);
        txn(0, 1'b0, IO, 32'd0);
        chk("io_rd_a5", rdata[0], 32'h0000_00A5);

        // Out-of-range address aliasing onto word 44 must not touch it.
        txn(0, 1'b1, 32'd300, 32'h0000_FFFF);
        txn(0, 1'b0, 32'd300, 32'd0);
        chk("oor_rdata", rdata[0], 32'd0);
        txn(0, 1'b0, 32'd44, 32'd0);

        // Zero wait states.
        txn(1, 1'b0, 32'd2, 32'd0);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, 255));
                2:       a = IO;
                default: a = 32'd256 + 32'($urandom_range(0, 1 << 20));
            endcase
            txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
